// File: rtl/sensor_link_pkg.sv
// Shared definitions for the sensor serial link: frame geometry, field widths
// and the transmitter FSM state encoding.
package sensor_link_pkg;

    localparam int FRAME_BITS   = 27;
    localparam int PAYLOAD_BITS = 24;
    localparam int TEMP_W       = 8;
    localparam int PRES_W       = 4;
    localparam int RAD_W        = 12;
    localparam int CNT_W        = 8;
    localparam int IDX_W        = 5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    // Odd parity is simply the inverse of the even-parity XOR.
    function automatic logic frame_parity(input logic [PAYLOAD_BITS-1:0] payload,
                                          input logic                    even);
        return (^payload) ^ ~even;
    endfunction

endpackage

// File: rtl/sensor_link_tx_bit_timer.sv
// Baud tick generator: tick marks the last cycle of each CLKS_PER_BIT-long bit;
// load restarts the bit period so the first bit is aligned to the accept edge.
module bit_timer
    import sensor_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q - CNT_W'(1);
        // Auto-reload at zero keeps consecutive bits back to back without a gap.
        if (load || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/sensor_link_tx.sv
// Serialises a {radiacao, pressao, temp} reading as start, 24 data bits LSB
// first, parity and stop, each bit held for CLKS_PER_BIT cycles.
module sensor_link_tx
    import sensor_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EVEN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TEMP_W-1:0] temp,
    input  logic [PRES_W-1:0] pressao,
    input  logic [RAD_W-1:0]  radiacao,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam logic EVEN_SEL = (PARITY_EVEN != 0);

    state_e                  state_q,   state_d;
    logic [PAYLOAD_BITS-1:0] shift_q,   shift_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic                    parity_q,  parity_d;
    logic [PAYLOAD_BITS-1:0] payload;
    logic                    load;
    logic                    tick;

    assign payload = {radiacao, pressao, temp};

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        parity_d   = parity_q;
        load       = 1'b0;
        tx         = 1'b1;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d   = START;
                    shift_d   = payload;
                    parity_d  = frame_parity(payload, EVEN_SEL);
                    bit_idx_d = '0;
                    load      = 1'b1;
                end
            end
            START: begin
                tx = 1'b0;
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_W'(PAYLOAD_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                tx = parity_q;
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset has priority so a valid seen while rst_n is low is never taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = ~ready;

endmodule

// File: doc/sensor_link_tx.md
SENSOR_LINK_TX -- requirements
Module: sensor_link_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 1..255.
REQ-002 The block SHALL have parameter PARITY_EVEN, default 1; 1 selects even parity, 0 selects odd parity.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 The block SHALL have port temp  input  8  temperature reading, unsigned degrees.
REQ-006 The block SHALL have port pressao  input  4  pressure reading, unsigned.
REQ-007 The block SHALL have port radiacao  input  12  radiation reading, unsigned.
REQ-008 The block SHALL have port valid  input  1  reading triple is valid this cycle.
REQ-009 The block SHALL have port ready  output  1  block can accept a triple this cycle.
REQ-010 The block SHALL have port tx  output  1  serial line to control room; idle high.
REQ-011 The block SHALL have port busy  output  1  frame in progress.
REQ-012 The block SHALL have port frame_done  output  1  one-cycle pulse in the last cycle of a stop bit.

Function
REQ-013 Accept SHALL occur on a rising edge where valid=1 and ready=1; temp, pressao and radiacao SHALL be captured into a 24-bit shift register on that edge.
REQ-014 The payload SHALL be {radiacao, pressao, temp}, sent LSB first: temp[0] first, radiacao[11] last.
REQ-015 The frame SHALL be: start bit (0), 24 payload bits, parity bit, stop bit (1); 27 bits in total.
REQ-016 The parity bit SHALL be the XOR of the 24 payload bits when PARITY_EVEN=1, and its inverse when PARITY_EVEN=0.
REQ-017 Each bit SHALL be driven on tx for exactly CLKS_PER_BIT consecutive cycles.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-019 Transitions: IDLE->START on accept; START->DATA after CLKS_PER_BIT cycles; DATA->PARITY after 24 bits; PARITY->STOP after CLKS_PER_BIT cycles; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-020 tx SHALL go low in the first cycle after the accept edge; latency from accept to start bit is 1 cycle.
REQ-021 ready SHALL be 1 only in IDLE; busy SHALL be the inverse of ready.
REQ-022 valid during busy SHALL be ignored; no queuing and no error flag.
REQ-023 Input changes after accept SHALL NOT affect the frame in flight.
REQ-024 Back-to-back: ready SHALL return high in the cycle after frame_done, giving a minimum accept-to-accept spacing of 27*CLKS_PER_BIT+1 cycles.
REQ-025 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle and no bit may be skipped or repeated.
REQ-026 The bit-cycle counter SHALL be 8 bits and the bit index counter 5 bits; neither SHALL wrap during a legal frame.

Reset
REQ-027 While rst_n=0 at an edge, the block SHALL set state=IDLE, tx=1, ready=1 after release, busy=0, frame_done=0, and clear both counters and the shift register.
REQ-028 Reset mid-frame SHALL abort the frame immediately, with tx=1 from the following cycle and no frame_done pulse.
REQ-029 valid asserted in the same cycle that rst_n=0 SHALL NOT be accepted.

Structure
REQ-030 Package sensor_link_pkg SHALL hold the FSM state enum, FRAME_BITS=27, PAYLOAD_BITS=24, and payload field widths 8/4/12.
REQ-031 The baud-tick counter SHALL be a sub-module named bit_timer (load, tick output), reused by the future receiver.

Verification
REQ-032 Scenario: CLKS_PER_BIT=4; temp=41, pressao=0, radiacao=0, valid pulse -> tx shows 0, bits 1,0,0,1,0,1,0,0, then 16 zeros, parity 1, stop 1, each bit 4 cycles; frame_done at cycle 108.
REQ-033 Scenario: temp=8'hFF, pressao=4'hF, radiacao=12'hFFF, PARITY_EVEN=1 -> 24 ones, parity 0; with PARITY_EVEN=0 -> parity 1.
REQ-034 Scenario: valid held high continuously, CLKS_PER_BIT=1 -> accepts exactly 28 cycles apart, with no idle-high gap beyond the stop bit plus 1 cycle.
REQ-035 Scenario: valid pulse while busy with different data -> ignored; the in-flight frame is unchanged; no extra frame follows.
REQ-036 Scenario: rst_n low for 1 cycle at payload bit 10 -> tx=1 the next cycle, ready=1 after release, no frame_done.
REQ-037 Scenario: temp swept 0..100 step 2, one frame each -> decoded payload equals the driven value on every frame, 0 mismatches reported.
